// File: rtl/handshake_const_check_if.sv
// Handshake bundle for handshake_const_check: data-token input channel plus
// the dataless control-token output channel.
interface handshake_const_check_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] ins;
    logic                  ins_valid;
    logic                  ins_ready;
    logic                  ctrl_valid;
    logic                  ctrl_ready;

    // master: the surrounding netlist (token producer and ctrl consumer)
    modport master (
        output ins, ins_valid, ctrl_ready,
        input  ins_ready, ctrl_valid
    );

    // slave: the checker itself
    modport slave (
        input  ins, ins_valid, ctrl_ready,
        output ins_ready, ctrl_valid
    );
endinterface

// File: rtl/handshake_const_check.sv
// Token checker: accepts data tokens, compares to EXPECTED, forwards one dataless
// ctrl token each, keeps saturating debug counts. Optional halt: HANDSHAKE_CONST_CHECK_HALT_EN.
module handshake_const_check #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned EXPECTED   = 3,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    handshake_const_check_if.slave hs,
    input  logic                   clear,
    output logic [CNT_WIDTH-1:0]   token_count,
    output logic [CNT_WIDTH-1:0]   err_count,
    output logic                   mismatch,
    output logic [DATA_WIDTH-1:0]  first_bad
);

    localparam logic [1:0] ST_EMPTY  = 2'd0;
    localparam logic [1:0] ST_FULL   = 2'd1;
`ifdef HANDSHAKE_CONST_CHECK_HALT_EN
    localparam logic [1:0] ST_HALTED = 2'd2;
`endif

    localparam logic [DATA_WIDTH-1:0] EXP_V   = DATA_WIDTH'(EXPECTED);
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX = '1;

    logic [1:0]            state_q, state_d;
    logic [CNT_WIDTH-1:0]  tok_q, tok_d;
    logic [CNT_WIDTH-1:0]  err_q, err_d;
    logic                  mis_q, mis_d;
    logic [DATA_WIDTH-1:0] first_q, first_d;
    logic                  halt_pend_q;
    logic                  ready;
    logic                  acc;
    logic                  emit;
    logic                  bad;

    assign acc  = hs.ins_valid & ready;
    assign emit = (state_q == ST_FULL) & hs.ctrl_ready;
    assign bad  = (hs.ins != EXP_V);

    assign hs.ins_ready  = ready;
    assign hs.ctrl_valid = (state_q == ST_FULL);

    always_comb begin
        ready = 1'b0;
        case (state_q)
            ST_EMPTY: ready = 1'b1;
            ST_FULL:  ready = hs.ctrl_ready & ~halt_pend_q;
            default:  ready = 1'b0;
        endcase
    end

`ifdef HANDSHAKE_CONST_CHECK_HALT_EN
    logic halt_pend_d;

    // A mismatch arms the halt; it takes effect once the forwarded token drains.
    always_comb begin
        halt_pend_d = halt_pend_q;
        if (clear)
            halt_pend_d = 1'b0;
        else if (acc && bad)
            halt_pend_d = 1'b1;
        else if (emit)
            halt_pend_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            halt_pend_q <= 1'b0;
        else
            halt_pend_q <= halt_pend_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (acc) state_d = ST_FULL;
            ST_FULL: begin
                if (emit && halt_pend_q && !clear)
                    state_d = ST_HALTED;
                else if (emit && !acc)
                    state_d = ST_EMPTY;
            end
            ST_HALTED: if (clear) state_d = ST_EMPTY;
            default:   state_d = ST_EMPTY;
        endcase
    end
`else
    assign halt_pend_q = 1'b0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (acc) state_d = ST_FULL;
            ST_FULL:  if (emit && !acc) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end
`endif

    // clear outranks the accept: a token taken during clear is forwarded but not counted
    always_comb begin
        tok_d   = tok_q;
        err_d   = err_q;
        mis_d   = mis_q;
        first_d = first_q;
        if (clear) begin
            tok_d   = '0;
            err_d   = '0;
            mis_d   = 1'b0;
            first_d = '0;
        end else if (acc) begin
            if (tok_q != CNT_MAX)
                tok_d = tok_q + 1'b1;
            if (bad) begin
                if (err_q != CNT_MAX)
                    err_d = err_q + 1'b1;
                mis_d = 1'b1;
                if (!mis_q)
                    first_d = hs.ins;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            tok_q   <= '0;
            err_q   <= '0;
            mis_q   <= 1'b0;
            first_q <= '0;
        end else begin
            state_q <= state_d;
            tok_q   <= tok_d;
            err_q   <= err_d;
            mis_q   <= mis_d;
            first_q <= first_d;
        end
    end

    assign token_count = tok_q;
    assign err_count   = err_q;
    assign mismatch    = mis_q;
    assign first_bad   = first_q;

endmodule
